// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one SEG-bit segment is resolved per stage,
// with the segment carry, partial result and zero status registered between stages.
module pipelined_cla_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    input  logic             i_carry,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero
);
    localparam int STAGES = WIDTH / SEG;

    if (WIDTH < 1 || SEG < 1 || (WIDTH % SEG) != 0) begin : g_param_check
        $fatal(1, "pipelined_cla_addsub: SEG must be >= 1 and divide WIDTH");
    end

    // Handshake: an input transfers on an edge with i_valid & o_ready, a result on an edge
    // with o_valid & i_ready. The whole pipeline moves together (adv) or holds together.
    logic adv;
    assign adv     = !o_valid || i_ready;
    assign o_ready = adv;

    // Index k is the input of stage k; index 0 is the operand port, index STAGES the output.
    logic             st_v [STAGES+1];
    logic [WIDTH-1:0] st_s [STAGES+1];
    logic             st_c [STAGES+1];
    logic             st_z [STAGES+1];
    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic             ovf_q;

    assign st_v[0] = i_valid;
    assign st_s[0] = '0;
    assign st_c[0] = i_sub ^ i_carry;
    assign st_z[0] = 1'b1;
    assign st_a[0] = i_a;
    assign st_b[0] = i_b ^ {WIDTH{i_sub}};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0]   seg_a;
        logic [SEG-1:0]   seg_b;
        logic [SEG-1:0]   seg_g;
        logic [SEG-1:0]   seg_p;
        logic [SEG-1:0]   seg_sum;
        logic [SEG:0]     seg_c;
        logic [WIDTH-1:0] sum_next;
        logic             v_q;
        logic             c_q;
        logic             z_q;
        logic [WIDTH-1:0] s_q;

        always_comb begin
            seg_a    = st_a[k][k*SEG +: SEG];
            seg_b    = st_b[k][k*SEG +: SEG];
            seg_g    = seg_a & seg_b;
            seg_p    = seg_a | seg_b;
            seg_c    = '0;
            seg_c[0] = st_c[k];
            for (int i = 0; i < SEG; i++) begin
                seg_c[i+1] = seg_g[i] | (seg_p[i] & seg_c[i]);
            end
            seg_sum  = seg_a ^ seg_b ^ seg_c[SEG-1:0];
            sum_next = st_s[k];
            sum_next[k*SEG +: SEG] = seg_sum;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                s_q <= '0;
                c_q <= 1'b0;
                z_q <= 1'b0;
            end else if (adv) begin
                v_q <= st_v[k];
                s_q <= sum_next;
                c_q <= seg_c[SEG];
                z_q <= st_z[k] & (seg_sum == '0);
            end
        end

        assign st_v[k+1] = v_q;
        assign st_s[k+1] = s_q;
        assign st_c[k+1] = c_q;
        assign st_z[k+1] = z_q;

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= st_a[k];
                    b_q <= st_b[k];
                end
            end

            assign st_a[k+1] = a_q;
            assign st_b[k+1] = b_q;
        end else begin : g_last
            // Carry into the MSB is internal to the top segment, so overflow is formed here.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= seg_c[SEG-1] ^ seg_c[SEG];
                end
            end
        end
    end

    assign o_valid    = st_v[STAGES];
    assign o_result   = st_s[STAGES];
    assign o_carry    = st_c[STAGES];
    assign o_zero     = st_z[STAGES];
    assign o_overflow = ovf_q;

endmodule

// File: doc/pipelined_cla_addsub.md
# pipelined_cla_addsub

Pipelined, parametrised carry-lookahead adder/subtractor with a valid/ready handshake, carry/borrow input and status flags. The operand is split into SEG-bit segments, and each segment is resolved by a combinational lookahead unit in its own pipeline stage. The segment carry is registered between stages. The block sits in the datapath between operand-select logic and the ALU result mux, and accepts one operation per cycle.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits; must be ≥ 1.
- SEG, 8, segment width resolved per stage; must divide WIDTH exactly, otherwise elaboration fails.
- STAGES (localparam), WIDTH/SEG, number of pipeline stages and the latency in cycles.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input operation present.
- o_ready  out  1  block accepts an input this cycle.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_sub  in  1  0 selects A+B+cin; 1 selects A−B−borrow.
- i_carry  in  1  carry-in for add, or borrow-in for subtract.
- o_valid  out  1  result present.
- i_ready  in  1  downstream accepts the result.
- o_result  out  WIDTH  sum or difference.
- o_carry  out  1  raw carry-out of the MSB (for subtract, 1 = no borrow).
- o_overflow  out  1  signed overflow.
- o_zero  out  1  o_result == 0.

## Operation
- Effective B: i_sub ? ~i_b : i_b. Effective cin: i_sub ? ~i_carry : i_carry.
- Stage k (k = 1..STAGES) computes segment k−1, bits [k·SEG−1 : (k−1)·SEG].
  - Per bit: G = a&b and P = a|b, with carry chain c[i+1] = G[i] | P[i]&c[i].
  - Sum bit = a^b^c.
  - The stage registers its sum segment, its segment carry-out, and the still-unprocessed upper operand bits.
- Lower result segments are carried forward unchanged through later stages; the final stage holds the complete result.
- Flags are computed in the final stage from registered data:
  - o_carry = carry out of bit WIDTH−1.
  - o_overflow = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
  - o_zero = AND of per-segment "segment == 0" bits, accumulated through the stages.
- Each stage has a valid bit.
- Global advance: adv = !o_valid | i_ready.
  - o_ready = adv.
  - When adv is high, every stage loads from the previous stage, and stage 1 loads {i_valid, operands}.
  - When adv is low, all stages hold.
- Bubbles are not compressed: an empty stage advances only when the pipeline advances.
- STAGES = 1 degenerates to a single registered full-width lookahead adder.

## Timing
- Reset (rst = 1 at an edge):
  - All stage valid bits clear, o_valid = 0.
  - o_result = 0, o_carry = 0, o_overflow = 0, o_zero = 0.
  - o_ready = 1 on the following cycle.
- An input is accepted at an edge where i_valid & o_ready. Its result is presented with o_valid = 1 exactly STAGES edges later, if no stall occurs.
- Throughput is one operation per cycle while i_ready = 1.
- Output handshake: the result is transferred at an edge where o_valid & i_ready.
  - While o_valid & !i_ready, o_result and all flags stay stable and o_ready = 0.
  - Inputs presented during this time are not accepted.
  - Upstream must hold its operation until o_ready = 1.
- Simultaneous output transfer and input acceptance in the same cycle is required and loses nothing.
- Reset mid-operation: every in-flight operation is discarded. No result from before reset may appear afterwards.
- rst has priority over every handshake event in the same cycle.
- Combinational depth per stage is bounded by SEG, not WIDTH.

## Test plan
- WIDTH=32, SEG=8: add 0x0000_0001 + 0xFFFF_FFFF, cin=0 → after 4 cycles o_valid=1, o_result=0x0000_0000, o_carry=1, o_zero=1, o_overflow=0.
- Add 0x7FFF_FFFF + 0x0000_0001, cin=1 → o_result=0x8000_0001, o_overflow=1, o_carry=0, o_zero=0.
- Subtract:
  - 5 − 7 with borrow 0 → 0xFFFF_FFFE, o_carry=0, o_overflow=0.
  - 0x8000_0000 − 1 with borrow 0 → 0x7FFF_FFFF, o_carry=1, o_overflow=1.
  - 10 − 3 with borrow 1 → 0x0000_0006.
- Eight back-to-back adds (i+1 + 0x100·i), with i_ready held low for 3 cycles starting when the first result appears:
  - Results arrive in order with none lost or duplicated.
  - Outputs are stable and o_ready=0 during the stall.
  - Throughput returns to 1/cycle after the stall.
- Assert rst for one cycle with 3 operations in flight:
  - The next cycle shows o_valid=0 and all outputs 0.
  - Only operations accepted after reset ever appear.
- Randomised operands, i_sub, i_carry, i_valid and i_ready against a reference model, for (WIDTH, SEG) = (32,8), (16,4), (8,8) and (12,3). Every result and flag must match, with latency STAGES when not stalled.
